mul_seq_ctrl: RTL and testbench



---
 rtl/mul_seq_pkg.sv | 22 ++
 rtl/mul_pipe.sv | 41 ++++
 rtl/mul_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_mul_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and widths for the 16x32 multiply sequencer and its 16x16 multiplier.
package mul_seq_pkg;

    localparam int A_W    = 16;
    localparam int B_W    = 32;
    localparam int OUT_W  = 32;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        ISSUE_HI,
        WAIT,
        DONE
    } state_t;

    // The hi partial product lands 16 bits up; its top half falls off the 32-bit result.
    function automatic logic [OUT_W-1:0] hi_term(input logic [OUT_W-1:0] p);
        return {p[HALF_W-1:0], {HALF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/mul_pipe.sv
// Unsigned 16x16 multiplier with MUL_LAT output register stages and a resettable valid chain.
module mul_pipe
    import mul_seq_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [HALF_W-1:0] in_a,
    input  logic [HALF_W-1:0] in_b,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_p
);

    logic [OUT_W-1:0]   prod_q [MUL_LAT];
    logic [MUL_LAT-1:0] vld_q;

    // Data stages stay unreset so the multiply and its pipeline registers pack into one DSP.
    always_ff @(posedge clk) begin
        prod_q[0] <= OUT_W'(in_a) * OUT_W'(in_b);
        for (int i = 1; i < MUL_LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < MUL_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[MUL_LAT-1];
    assign out_p     = prod_q[MUL_LAT-1];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Computes (a*b) mod 2^32 for 16-bit a and 32-bit b by issuing two halves through one 16x16 multiplier.
//
// state    | meaning
// IDLE     | ready for a request; operands latched on accept
// ISSUE_LO | multiplier captures a * b[15:0]
// ISSUE_HI | multiplier captures a * b[31:16]
// WAIT     | accumulating products as they return, in issue order
// DONE     | result presented until the sink takes it
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [A_W-1:0]   req_a,
    input  logic [B_W-1:0]   req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t              state;
    logic [A_W-1:0]      a_q;
    logic [HALF_W-1:0]   b_hi_q;
    logic [HALF_W-1:0]   mul_b;
    logic                mul_vld;
    logic                need_hi;
    logic                got_lo;
    logic [1:0]          ret_left;
    logic [OUT_W-1:0]    acc;
    logic                mul_out_valid;
    logic [OUT_W-1:0]    mul_out_p;

    mul_pipe #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (mul_vld),
        .in_a      (a_q),
        .in_b      (mul_b),
        .out_valid (mul_out_valid),
        .out_p     (mul_out_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            op_count  <= '0;
            acc       <= '0;
            a_q       <= '0;
            b_hi_q    <= '0;
            mul_b     <= '0;
            mul_vld   <= 1'b0;
            need_hi   <= 1'b0;
            got_lo    <= 1'b0;
            ret_left  <= '0;
        end else begin
            mul_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q       <= req_a;
                        b_hi_q    <= req_b[B_W-1:HALF_W];
                        mul_b     <= req_b[HALF_W-1:0];
                        mul_vld   <= 1'b1;
                        need_hi   <= |req_b[B_W-1:HALF_W];
                        ret_left  <= (|req_b[B_W-1:HALF_W]) ? 2'd2 : 2'd1;
                        got_lo    <= 1'b0;
                        acc       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ISSUE_LO;
                    end
                end
                ISSUE_LO: begin
                    if (need_hi) begin
                        mul_b   <= b_hi_q;
                        mul_vld <= 1'b1;
                        state   <= ISSUE_HI;
                    end else begin
                        state <= WAIT;
                    end
                end
                // With a one-stage multiplier the lo product already returns during ISSUE_HI.
                ISSUE_HI, WAIT: begin
                    state <= WAIT;
                    if (mul_out_valid) begin
                        acc      <= got_lo ? acc + hi_term(mul_out_p) : acc + mul_out_p;
                        got_lo   <= 1'b1;
                        ret_left <= ret_left - 2'd1;
                        if (ret_left == 2'd1) begin
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        op_count  <= op_count + CNT_W'(1);
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign rsp_data = acc;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: vector table plus backpressure, reset-abort and counter-wrap sequences.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        busy;
    logic [1:0]  op_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int issue_cnt = 0;
    logic [1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.MUL_LAT(2), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    always @(posedge clk) if (dut.mul_vld) issue_cnt++;

    typedef struct {
        logic [15:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_data"},  rsp_data,       32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " op_count"},  32'(op_count),  32'd0);
    endtask

    // Returns #1 after the accepting edge with junk on the request fields.
    task automatic accept(input logic [15:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = 16'hA5C3;
        req_b = 32'hDEAD_BEEF;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid) break;
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        int iss0;
        rsp_ready = 1'b1;
        iss0 = issue_cnt;
        accept(a, b);
        wait_rsp(lat);
        check({name, " data"}, rsp_data, exp);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " issues"}, 32'(issue_cnt - iss0), (b[31:16] == 16'h0) ? 32'd1 : 32'd2);
        @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 2'd1;
        check({name, " op_count"}, 32'(op_count), 32'(exp_cnt));
        check({name, " req_ready_after"}, 32'(req_ready), 32'd1);
        check({name, " rsp_valid_after"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int spurious;
        logic [15:0] ra;
        logic [31:0] rb;
        logic [47:0] full;
        logic [1:0]  cnt_seq [5];

        tbl[0] = '{16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_0001, 4};
        tbl[1] = '{16'h0003, 32'h0000_0005, 32'h0000_000F, 3};
        tbl[2] = '{16'h1234, 32'h0001_0000, 32'h1234_0000, 4};
        tbl[3] = '{16'h8000, 32'h0002_0003, 32'h0001_8000, 4};
        tbl[4] = '{16'h0000, 32'hFFFF_FFFF, 32'h0000_0000, 4};
        tbl[5] = '{16'hFFFF, 32'h0000_FFFF, 32'hFFFE_0001, 3};
        tbl[6] = '{16'h0001, 32'h1234_5678, 32'h1234_5678, 4};
        cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
        end

        // Backpressure: result held, no second accept, then handshake.
        rsp_ready = 1'b0;
        accept(16'd5, 32'd6);
        wait_rsp(lat);
        check("bp latency", 32'(lat), 32'd3);
        req_valid = 1'b1;
        req_a = 16'd1;
        req_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp rsp_data", rsp_data, 32'd30);
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp req_ready", 32'(req_ready), 32'd0);
            check("bp busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 2'd1;
        check("bp op_count", 32'(op_count), 32'(exp_cnt));
        check("bp req_ready_after", 32'(req_ready), 32'd1);
        check("bp busy_after", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = 16'hFFFF;
        req_b = 32'hFFFF_FFFF;
        wait_rsp(lat);
        check("bp second data", rsp_data, 32'd1);
        check("bp second latency", 32'(lat), 32'd3);
        @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 2'd1;
        check("bp second op_count", 32'(op_count), 32'(exp_cnt));

        // Reset in the cycle after ISSUE_HI.
        accept(16'hFFFF, 32'hFFFF_FFFF);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midop");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) spurious++;
        end
        check("midop spurious rsp", 32'(spurious), 32'd0);
        check("midop rsp_data idle", rsp_data, 32'd0);
        run_op("post_reset", 16'd7, 32'd9, 32'd63, 3);

        // Fresh reset, then five ops against a wide-product model with counter wrap.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        for (int i = 0; i < 5; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = $urandom;
            if (i == 2) rb[31:16] = 16'h0;
            full = {32'h0, ra} * {16'h0, rb};
            run_op($sformatf("b2b%0d", i), ra, rb, full[31:0], (rb[31:16] == 16'h0) ? 3 : 4);
            check($sformatf("b2b%0d count_seq", i), 32'(op_count), 32'(cnt_seq[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
